// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } mon_state_e;

  localparam int unsigned DEF_EXP_PERIOD = 3;
  localparam int unsigned DEF_TOL        = 0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a divided clock in clk cycles and reports
// lock, mismatch and stall status against an expected divide ratio.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             stall,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned DIFF_W = CNT_W + 1;
  localparam int unsigned MC_W   = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]         CNT_MAX  = '1;
  localparam logic [ERR_W-1:0]         ERR_MAX  = '1;
  localparam logic [MC_W-1:0]          LOCK_VAL = MC_W'(LOCK_CNT);
  localparam logic signed [DIFF_W-1:0] EXP_S    = DIFF_W'(EXP_PERIOD);
  localparam logic [DIFF_W-1:0]        TOL_U    = DIFF_W'(TOL);

  mon_state_e state_q, state_d;

  logic              s;
  logic              s_d_q;
  logic              re_q;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              meas_valid_q, meas_valid_d;
  logic              locked_q, locked_d;
  logic              mismatch_q, mismatch_d;
  logic              stall_q, stall_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [MC_W-1:0]   match_cnt_q, match_cnt_d;

  logic signed [DIFF_W-1:0] diff;
  logic [DIFF_W-1:0]        abs_diff;
  logic                     is_match;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (clk_in),
    .q_o   (s)
  );

  // Edge detect; s_d_q also feeds the high counter so it lines up with re_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_q <= 1'b0;
      re_q  <= 1'b0;
    end else begin
      s_d_q <= s;
      re_q  <= s & ~s_d_q;
    end
  end

  assign diff     = $signed({1'b0, period_cnt_q}) - EXP_S;
  assign abs_diff = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);
  assign is_match = (abs_diff <= TOL_U);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      mismatch_q   <= 1'b0;
      stall_q      <= 1'b0;
      err_q        <= '0;
      match_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      mismatch_q   <= mismatch_d;
      stall_q      <= stall_d;
      err_q        <= err_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    mismatch_d   = 1'b0;
    stall_d      = 1'b0;
    err_d        = err_q;
    match_cnt_d  = match_cnt_q;

    if (!en) begin
      state_d     = ST_IDLE;
      locked_d    = 1'b0;
      match_cnt_d = '0;
      err_d       = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (re_q) begin
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
            state_d      = ST_MEAS;
          end
        end
        ST_MEAS: begin
          // A rising edge wins over a simultaneous timeout.
          if (re_q) begin
            period_d     = period_cnt_q;
            high_d       = high_cnt_q;
            meas_valid_d = 1'b1;
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
            if (is_match) begin
              if (match_cnt_q != LOCK_VAL) match_cnt_d = match_cnt_q + 1'b1;
              if (match_cnt_q >= LOCK_VAL - MC_W'(1)) locked_d = 1'b1;
            end else begin
              mismatch_d  = 1'b1;
              match_cnt_d = '0;
              locked_d    = 1'b0;
              if (locked_q && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
            end
          end else if (period_cnt_q == CNT_MAX) begin
            stall_d     = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            state_d     = ST_ARM;
          end else begin
            period_cnt_d = period_cnt_q + 1'b1;
            if (s_d_q) high_cnt_d = high_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign period_o   = period_q;
  assign high_o     = high_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign stall      = stall_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench: dut0 (TOL=0) and dut1 (TOL=1) driven by directed clk_in patterns.
module tb_clk_div_monitor;

  localparam int EXP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic ci0 = 1'b0, ci1 = 1'b0;

  logic [7:0] per0, hi0, err0, per1, hi1, err1;
  logic       mv0, lk0, mm0, st0, mv1, lk1, mm1, st1;

  always #5 clk = ~clk;

  clk_div_monitor #(.CNT_W(8), .EXP_PERIOD(3), .TOL(0), .LOCK_CNT(4), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .clk_in(ci0),
    .period_o(per0), .high_o(hi0), .meas_valid(mv0), .locked(lk0),
    .mismatch(mm0), .stall(st0), .err_cnt(err0)
  );

  clk_div_monitor #(.CNT_W(8), .EXP_PERIOD(3), .TOL(1), .LOCK_CNT(4), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .clk_in(ci1),
    .period_o(per1), .high_o(hi1), .meas_valid(mv1), .locked(lk1),
    .mismatch(mm1), .stall(st1), .err_cnt(err1)
  );

  typedef struct {
    int p;
    int h;
    bit mm;
    bit lk;
    int err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int tests = 0;
  int fails = 0;
  int mc[2]  = '{0, 0};
  int err[2] = '{0, 0};
  int pp[2]  = '{0, 0};
  int ph[2]  = '{0, 0};
  int tol[2] = '{0, 1};
  bit lk[2]  = '{1'b0, 1'b0};
  bit pv[2]  = '{1'b0, 1'b0};
  int cyc = 0;
  int rise0 = 0;
  int stall_seen = 0;
  int stall1_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference behaviour for one completed rise-to-rise interval.
  function automatic void model_push(input int d, input int p, input int h);
    exp_t e;
    int diff;
    diff = p - EXP;
    if (diff < 0) diff = -diff;
    e.p = p;
    e.h = h;
    if (diff <= tol[d]) begin
      e.mm = 1'b0;
      if (mc[d] < 4) mc[d]++;
      if (mc[d] == 4) lk[d] = 1'b1;
    end else begin
      e.mm = 1'b1;
      if (lk[d] && err[d] < 255) err[d]++;
      mc[d] = 0;
      lk[d] = 1'b0;
    end
    e.lk  = lk[d];
    e.err = err[d];
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // One clk_in period: high for h cycles, low for p-h cycles.
  task automatic period(input int d, input int p, input int h);
    if (pv[d]) model_push(d, pp[d], ph[d]);
    pp[d] = p;
    ph[d] = h;
    pv[d] = (d == 0) ? en0 : en1;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (i == 0 && d == 0) rise0 = cyc;
      if (d == 0) ci0 = (i < h);
      else ci1 = (i < h);
    end
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (d == 0) ci0 = 1'b0;
      else ci1 = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mv0) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut0 unexpected meas_valid: period_o=%0d", per0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 period_o", per0, e0.p);
        chk("dut0 high_o", hi0, e0.h);
        chk("dut0 mismatch", mm0, e0.mm);
        chk("dut0 locked", lk0, e0.lk);
        chk("dut0 err_cnt", err0, e0.err);
      end
    end else if (mm0) begin
      chk("dut0 mismatch without meas_valid", mm0, 0);
    end
    if (st0) begin
      stall_seen++;
      tests++;
      if ((cyc - rise0) < 259 || (cyc - rise0) > 260) begin
        fails++;
        $display("FAIL dut0 stall timing: got %0d cycles after rise expected 259..260", cyc - rise0);
      end
      chk("dut0 locked with stall", lk0, 0);
    end
    if (mv1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut1 unexpected meas_valid: period_o=%0d", per1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 period_o", per1, e1.p);
        chk("dut1 high_o", hi1, e1.h);
        chk("dut1 mismatch", mm1, e1.mm);
        chk("dut1 locked", lk1, e1.lk);
        chk("dut1 err_cnt", err1, e1.err);
      end
    end
    if (st1) stall1_seen++;
  end

  task automatic seq0();
    idle(0, 4);
    repeat (6) period(0, 3, 1);
    repeat (6) period(0, 3, 2);
    period(0, 5, 1);
    repeat (5) period(0, 3, 1);
    // Long low hold: the pending interval is lost to a stall.
    idle(0, 300);
    pv[0] = 1'b0;
    mc[0] = 0;
    lk[0] = 1'b0;
    chk("dut0 stall count", stall_seen, 1);
    chk("dut0 locked after stall", lk0, 0);
    repeat (3) period(0, 3, 1);
    chk("dut0 err_cnt before en drop", err0, 1);
    fork
      period(0, 8, 1);
      begin
        repeat (6) @(negedge clk);
        en0 = 1'b0;
        pv[0] = 1'b0;
        mc[0] = 0;
        lk[0] = 1'b0;
        err[0] = 0;
      end
    join
    chk("dut0 err_cnt while disabled", err0, 0);
    chk("dut0 locked while disabled", lk0, 0);
    repeat (3) period(0, 3, 1);
    idle(0, 6);
    en0 = 1'b1;
    idle(0, 6);
    repeat (4) period(0, 3, 1);
    idle(0, 8);
  endtask

  task automatic seq1();
    int pat[9];
    pat = '{3, 4, 3, 4, 2, 3, 5, 3, 3};
    idle(1, 4);
    for (int i = 0; i < 9; i++) period(1, pat[i], 1);
    idle(1, 8);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset period_o", per0, 0);
    chk("reset high_o", hi0, 0);
    chk("reset meas_valid", mv0, 0);
    chk("reset locked", lk0, 0);
    chk("reset mismatch", mm0, 0);
    chk("reset stall", st0, 0);
    chk("reset err_cnt", err0, 0);
    rst_n = 1'b1;
    en0 = 1'b1;
    en1 = 1'b1;
    fork
      seq0();
      seq1();
    join
    repeat (20) @(negedge clk);
    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    chk("dut0 total stalls", stall_seen, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
